// File: rtl/mem_responder_pkg.sv
// Shared state type, default sizes and decoder target bit positions for mem_responder.
package mem_responder_pkg;

   localparam int N_SLAVES_DEFAULT = 11;
   localparam int DW_DEFAULT       = 32;

   // Chip-select bit positions as produced by the address decoder.
   localparam int SRAM_BIT       = 0;
   localparam int DRAM_BIT       = 1;
   localparam int FLASH_BIT      = 2;
   localparam int ENCODER_BIT    = 3;
   localparam int SERIAL0_BIT    = 4;
   localparam int SERIAL1_BIT    = 5;
   localparam int KBD_BIT        = 6;
   localparam int SWITCH_BIT     = 7;
   localparam int SERIAL2_BIT    = 8;
   localparam int LED_MATRIX_BIT = 9;
   localparam int MONITOR_BIT    = 10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter for mem_responder; only built when MEM_RESPONDER_TIMEOUT_EN is defined.
module mem_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   logic [15:0] count_q, count_d;

   // Counting stops at expiry so the counter can never wrap while a cycle is held.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expire_o) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = enable_i && (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mem_responder.sv
// Bus responder: strobes the decoded target, returns its data or a one-cycle bus error.
// Define MEM_RESPONDER_TIMEOUT_EN to add the wait-cycle timeout watchdog.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int N_SLAVES = N_SLAVES_DEFAULT,
   parameter int DW       = DW_DEFAULT,
   parameter int TIMEOUT  = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cyc_i,
   input  logic                   stb_i,
   input  logic                   we_i,
   input  logic [N_SLAVES-1:0]    sel_i,
   input  logic                   invalid_i,
   input  logic [N_SLAVES-1:0]    slave_ack_i,
   input  logic [N_SLAVES*DW-1:0] slave_dat_i,
   output logic [N_SLAVES-1:0]    slave_stb_o,
   output logic                   slave_we_o,
   output logic [DW-1:0]          dat_o,
   output logic                   ack_o,
   output logic                   err_o,
   output logic                   busy_o
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("mem_responder: TIMEOUT must lie in 1..65535");
   end

   state_t              state_q, state_d;
   logic [N_SLAVES-1:0] sel_q, sel_d;
   logic                we_q, we_d;
   logic [DW-1:0]       dat_q, dat_d;
   logic [DW-1:0]       rd_data;
   logic                sel_onehot;
   logic                hit;
   logic                expire;

   assign sel_onehot = (sel_i != '0) && ((sel_i & (sel_i - N_SLAVES'(1))) == '0);
   assign hit        = |(slave_ack_i & sel_q);

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (sel_q[k]) begin
            rd_data = slave_dat_i[k*DW +: DW];
         end
      end
   end

`ifdef MEM_RESPONDER_TIMEOUT_EN
   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (state_q != WAIT),
      .enable_i (state_q == WAIT),
      .expire_o (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // A dropped cycle abandons the wait silently; an ack beats a same-cycle expiry.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      dat_d   = dat_q;
      unique case (state_q)
         IDLE: begin
            if (cyc_i && stb_i) begin
               sel_d   = sel_i;
               we_d    = we_i;
               state_d = (invalid_i || !sel_onehot) ? ERR : WAIT;
            end
         end
         WAIT: begin
            if (!cyc_i) begin
               state_d = IDLE;
            end else if (hit) begin
               dat_d   = rd_data;
               state_d = DONE;
            end else if (expire) begin
               state_d = ERR;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
      end
   end

   assign slave_stb_o = (state_q == WAIT) ? sel_q : '0;
   assign slave_we_o  = we_q;
   assign dat_o       = dat_q;
   assign ack_o       = (state_q == DONE);
   assign err_o       = (state_q == ERR);
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level reference plus directed vectors.
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int NS  = 11;
   localparam int W   = 32;
   localparam int TMO = 4;
`ifdef MEM_RESPONDER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc, stb, we, invalid;
   logic [NS-1:0] sel, sack;
   logic [NS*W-1:0] sdat;
   logic [NS-1:0] stbOut;
   logic          weOut, ackOut, errOut, busyOut;
   logic [W-1:0]  datOut;

   int passCount  = 0;
   int checkCount = 0;
   bit checkEn    = 1'b0;

   // Reference: which target is pending (-1 = none), wait length, pulses, captured data.
   int           mPend = -1;
   int           mWait = 0;
   bit           mAck  = 1'b0;
   bit           mErr  = 1'b0;
   bit           mWe   = 1'b0;
   logic [W-1:0] mDat  = '0;

   always #5 clk = ~clk;

   mem_responder #(
      .N_SLAVES (NS),
      .DW       (W),
      .TIMEOUT  (TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cyc_i       (cyc),
      .stb_i       (stb),
      .we_i        (we),
      .sel_i       (sel),
      .invalid_i   (invalid),
      .slave_ack_i (sack),
      .slave_dat_i (sdat),
      .slave_stb_o (stbOut),
      .slave_we_o  (weOut),
      .dat_o       (datOut),
      .ack_o       (ackOut),
      .err_o       (errOut),
      .busy_o      (busyOut)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic s, input logic w,
                                input logic [NS-1:0] sl, input logic inv, input logic [NS-1:0] ak);
      cyc     = c;
      stb     = s;
      we      = w;
      sel     = sl;
      invalid = inv;
      sack    = ak;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         mPend <= -1;
         mWait <= 0;
         mAck  <= 1'b0;
         mErr  <= 1'b0;
         mWe   <= 1'b0;
         mDat  <= '0;
      end else if (mAck || mErr) begin
         mAck <= 1'b0;
         mErr <= 1'b0;
      end else if (mPend < 0) begin
         if (cyc && stb) begin
            mWe <= we;
            if (invalid || $countones(sel) != 1) begin
               mErr <= 1'b1;
            end else begin
               mWait <= 0;
               for (int k = 0; k < NS; k++) begin
                  if (sel[k]) mPend <= k;
               end
            end
         end
      end else if (!cyc) begin
         mPend <= -1;
      end else if (sack[mPend]) begin
         mDat  <= sdat[mPend*W +: W];
         mAck  <= 1'b1;
         mPend <= -1;
      end else if (TO_EN && mWait == TMO - 1) begin
         mErr  <= 1'b1;
         mPend <= -1;
      end else begin
         mWait <= mWait + 1;
      end
   end

   always @(negedge clk) begin
      logic [NS-1:0] expStb;
      if (checkEn) begin
         expStb = '0;
         if (mPend >= 0) expStb[mPend] = 1'b1;
         checkOutput("model stb", 32'(stbOut), 32'(expStb));
         checkOutput("model we", 32'(weOut), 32'(mWe));
         checkOutput("model dat", datOut, mDat);
         checkOutput("model ack", 32'(ackOut), 32'(mAck));
         checkOutput("model err", 32'(errOut), 32'(mErr));
         checkOutput("model busy", 32'(busyOut), 32'((mPend >= 0) || mAck || mErr));
      end
   end

   initial begin
      logic [NS-1:0] ackSeq [8];
      int nAck;

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      for (int k = 0; k < NS; k++) sdat[k*W +: W] = 32'hA5A5_0000 | 32'(k);
      sdat[SRAM_BIT*W +: W] = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      checkEn = 1'b1;
      checkOutput("reset busy", 32'(busyOut), 32'h0);
      checkOutput("reset stb", 32'(stbOut), 32'h0);
      checkOutput("reset dat", datOut, 32'h0);
      checkOutput("reset ack", 32'(ackOut), 32'h0);
      checkOutput("reset err", 32'(errOut), 32'h0);

      $display("[TB] sram read, earliest ack");
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h001, 1'b0, '0);
      @(negedge clk);
      checkOutput("sram stb", 32'(stbOut), 32'h001);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 11'h001);
      @(negedge clk);
      checkOutput("sram ack", 32'(ackOut), 32'h1);
      checkOutput("sram dat", datOut, 32'hDEAD_BEEF);
      checkOutput("sram err", 32'(errOut), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("sram ack single", 32'(ackOut), 32'h0);

      $display("[TB] invalid address");
      applyStimulus(1'b1, 1'b1, 1'b1, 11'h010, 1'b1, '0);
      @(negedge clk);
      checkOutput("invalid err", 32'(errOut), 32'h1);
      checkOutput("invalid stb", 32'(stbOut), 32'h0);
      checkOutput("invalid we", 32'(weOut), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("invalid err single", 32'(errOut), 32'h0);

      $display("[TB] flash select, stray ack from another target");
      ackSeq = '{11'h002, 11'h000, 11'h000, 11'h000, 11'h000, 11'h004, 11'h000, 11'h000};
      nAck = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h004, 1'b0, '0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, ackSeq[i]);
         @(negedge clk);
         nAck += int'(ackOut);
      end
      checkOutput("flash ack count", 32'(nAck), 32'd1);
      checkOutput("flash dat", datOut, 32'hA5A5_0002);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);

      $display("[TB] two chip selects");
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h005, 1'b0, '0);
      @(negedge clk);
      checkOutput("multi err", 32'(errOut), 32'h1);
      checkOutput("multi stb", 32'(stbOut), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("multi idle", 32'(busyOut), 32'h0);

      $display("[TB] reset during wait");
      applyStimulus(1'b1, 1'b1, 1'b1, 11'h008, 1'b0, '0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort busy", 32'(busyOut), 32'h0);
      checkOutput("abort stb", 32'(stbOut), 32'h0);
      checkOutput("abort we", 32'(weOut), 32'h0);
      checkOutput("abort dat", datOut, 32'h0);
      checkOutput("abort ack", 32'(ackOut), 32'h0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h008, 1'b0, '0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 11'h008);
      @(negedge clk);
      checkOutput("after abort ack", 32'(ackOut), 32'h1);
      checkOutput("after abort dat", datOut, 32'hA5A5_0003);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);

      $display("[TB] cycle dropped while waiting");
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h080, 1'b0, '0);
      @(negedge clk);
      checkOutput("drop stb", 32'(stbOut), 32'h080);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("drop busy", 32'(busyOut), 32'h0);
      checkOutput("drop ack", 32'(ackOut), 32'h0);
      checkOutput("drop err", 32'(errOut), 32'h0);

      $display("[TB] request held through completion");
      nAck = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h001, 1'b0, 11'h001);
      repeat (5) begin
         @(negedge clk);
         nAck += int'(ackOut);
      end
      checkOutput("held ack count", 32'(nAck), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);

      $display("[TB] no ack from monitor");
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h400, 1'b0, '0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (3) @(negedge clk);
      checkOutput("wait stb", 32'(stbOut), 32'h400);
      @(negedge clk);
`ifdef MEM_RESPONDER_TIMEOUT_EN
      checkOutput("timeout err", 32'(errOut), 32'h1);
      checkOutput("timeout stb", 32'(stbOut), 32'h0);
`else
      checkOutput("no timeout busy", 32'(busyOut), 32'h1);
      checkOutput("no timeout err", 32'(errOut), 32'h0);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);

      $display("[TB] ack on the last wait cycle");
      applyStimulus(1'b1, 1'b1, 1'b0, 11'h400, 1'b0, '0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (3) @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 11'h400);
      @(negedge clk);
      checkOutput("late ack", 32'(ackOut), 32'h1);
      checkOutput("late err", 32'(errOut), 32'h0);
      checkOutput("late dat", datOut, 32'hA5A5_000A);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);

      checkEn = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
